// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if
//   Bundles the request/grant handshake, playback controls and the Counter
//   control outputs of counter_sequencer.
//   master : the side that raises requests and watches grants (bench/system).
//   slave  : the sequencer itself.
//   Signals:
//     reqUser/modeUser, reqAuto/modeAuto : playback requests with their modes
//     repeats                            : pass count latched at grant (0 = forever)
//     pause, stop                        : playback controls
//     cntWrap                            : end-of-array pulse from the Counter
//     cntMode, cntEnb, cntReset          : Counter control outputs
//     grantUser, grantAuto               : one-cycle request acknowledges
//     busy, done, passCount              : playback status
interface counter_sequencer_if #(
  parameter int REP_W = 4
) ();
  logic             reqUser;
  logic [2:0]       modeUser;
  logic             reqAuto;
  logic [2:0]       modeAuto;
  logic [REP_W-1:0] repeats;
  logic             pause;
  logic             stop;
  logic             cntWrap;
  logic [2:0]       cntMode;
  logic             cntEnb;
  logic             cntReset;
  logic             grantUser;
  logic             grantAuto;
  logic             busy;
  logic             done;
  logic [REP_W-1:0] passCount;

  modport master (
    output reqUser, modeUser, reqAuto, modeAuto, repeats, pause, stop, cntWrap,
    input  cntMode, cntEnb, cntReset, grantUser, grantAuto, busy, done, passCount
  );

  modport slave (
    input  reqUser, modeUser, reqAuto, modeAuto, repeats, pause, stop, cntWrap,
    output cntMode, cntEnb, cntReset, grantUser, grantAuto, busy, done, passCount
  );
endinterface

// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Playback controller for the sample-index Counter. Arbitrates user and
//   auto playback requests (user wins, user may preempt auto), drives the
//   Counter's mode/enable/reset, divides the clock into an enable tick,
//   counts completed passes from the Counter's wrap pulse and handles
//   pause/stop. Every output is a register.
//   Ports:
//     clk     : system clock, rising edge
//     resetIn : synchronous active-high reset
//     seq     : counter_sequencer_if slave modport (requests, controls,
//               Counter control outputs and status)
//   Parameters:
//     CLK_DIV : cntEnb period in clocks while running (>= 2)
//     REP_W   : width of repeats and passCount
module counter_sequencer #(
  parameter int CLK_DIV = 4,
  parameter int REP_W   = 4
) (
  input  logic               clk,
  input  logic               resetIn,
  counter_sequencer_if.slave seq
);

  localparam int              DIV_W   = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_PAUSED,
    ST_FINISH
  } state_t;

  state_t           state_reg;
  logic [DIV_W-1:0] div_reg;
  logic [REP_W-1:0] pass_reg;
  logic [REP_W-1:0] rep_reg;
  logic             src_auto_reg;
  logic [2:0]       cnt_mode_reg;
  logic             cnt_enb_reg;
  logic             cnt_reset_reg;
  logic             gnt_user_reg;
  logic             gnt_auto_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             user_ok;
  logic             auto_ok;
  logic             take_user;
  logic             take_auto;
  logic [REP_W:0]   pass_inc;
  logic [REP_W-1:0] pass_sat;
  logic             last_pass;
  logic [DIV_W-1:0] div_adv;

  // Mode 0 means "nothing to play", so such requests never qualify.
  assign user_ok = seq.reqUser && (seq.modeUser != 3'd0);
  assign auto_ok = seq.reqAuto && (seq.modeAuto != 3'd0);

  // User is taken from IDLE, or as a preemption of a running/paused auto
  // playback. Auto is only ever taken from IDLE and only if user is absent.
  assign take_user = user_ok &&
                     ((state_reg == ST_IDLE) ||
                      (((state_reg == ST_RUN) || (state_reg == ST_PAUSED)) && src_auto_reg));
  assign take_auto = auto_ok && !user_ok && (state_reg == ST_IDLE);

  // One extra bit catches the carry so the pass counter saturates.
  assign pass_inc  = {1'b0, pass_reg} + (REP_W+1)'(1);
  assign pass_sat  = pass_inc[REP_W] ? pass_reg : pass_inc[REP_W-1:0];
  assign last_pass = (rep_reg != '0) && (pass_inc == {1'b0, rep_reg});

  assign div_adv = (div_reg == DIV_MAX) ? '0 : div_reg + DIV_W'(1);

  always_ff @(posedge clk) begin
    if (resetIn) begin
      state_reg     <= ST_IDLE;
      div_reg       <= '0;
      pass_reg      <= '0;
      rep_reg       <= '0;
      src_auto_reg  <= 1'b0;
      cnt_mode_reg  <= 3'd0;
      cnt_enb_reg   <= 1'b0;
      cnt_reset_reg <= 1'b0;
      gnt_user_reg  <= 1'b0;
      gnt_auto_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      // Pulse outputs default low; states below raise them for one cycle.
      gnt_user_reg  <= 1'b0;
      gnt_auto_reg  <= 1'b0;
      cnt_reset_reg <= 1'b0;
      done_reg      <= 1'b0;
      cnt_enb_reg   <= 1'b0;

      if ((state_reg != ST_IDLE) && seq.stop) begin
        // Abort beats everything else, including a final wrap or a request.
        state_reg     <= ST_IDLE;
        cnt_reset_reg <= 1'b1;
        pass_reg      <= '0;
        div_reg       <= '0;
        busy_reg      <= 1'b0;
      end else if (take_user || take_auto) begin
        state_reg     <= ST_LOAD;
        gnt_user_reg  <= take_user;
        gnt_auto_reg  <= take_auto;
        cnt_reset_reg <= 1'b1;
        cnt_mode_reg  <= take_user ? seq.modeUser : seq.modeAuto;
        rep_reg       <= seq.repeats;
        src_auto_reg  <= take_auto;
        div_reg       <= '0;
        pass_reg      <= '0;
        busy_reg      <= 1'b1;
      end else begin
        case (state_reg)
          ST_LOAD: begin
            state_reg <= ST_RUN;
          end
          ST_RUN: begin
            // A wrap is counted even when pause arrives in the same cycle.
            if (seq.cntWrap) begin
              pass_reg <= pass_sat;
            end
            if (seq.cntWrap && last_pass) begin
              state_reg <= ST_FINISH;
              done_reg  <= 1'b1;
            end else if (seq.pause) begin
              // Divider is frozen at its current value until resume.
              state_reg <= ST_PAUSED;
            end else begin
              div_reg     <= div_adv;
              cnt_enb_reg <= (div_adv == DIV_MAX);
            end
          end
          ST_PAUSED: begin
            // Resume re-enters RUN on the held divider value; wraps ignored here.
            if (!seq.pause) begin
              state_reg   <= ST_RUN;
              cnt_enb_reg <= (div_reg == DIV_MAX);
            end
          end
          ST_FINISH: begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
          default: begin
            // IDLE with no qualifying request: everything holds.
          end
        endcase
      end
    end
  end

  assign seq.cntMode   = cnt_mode_reg;
  assign seq.cntEnb    = cnt_enb_reg;
  assign seq.cntReset  = cnt_reset_reg;
  assign seq.grantUser = gnt_user_reg;
  assign seq.grantAuto = gnt_auto_reg;
  assign seq.busy      = busy_reg;
  assign seq.done      = done_reg;
  assign seq.passCount = pass_reg;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer
//   Self-checking bench for counter_sequencer (CLK_DIV=4, REP_W=4).
//   Each scenario drives inputs on the falling edge and pushes timed
//   expectations (cycle, signal, value) into a scoreboard queue; a monitor
//   on the falling edge pops every entry due in the current cycle and
//   compares it against the live DUT output.
module tb_counter_sequencer;

  localparam int CLK_DIV = 4;
  localparam int REP_W   = 4;

  localparam int S_MODE = 0;
  localparam int S_ENB  = 1;
  localparam int S_CRST = 2;
  localparam int S_GU   = 3;
  localparam int S_GA   = 4;
  localparam int S_BUSY = 5;
  localparam int S_DONE = 6;
  localparam int S_PASS = 7;

  typedef struct {
    int    cyc;
    int    sel;
    int    val;
    string tag;
  } exp_t;

  logic clk;
  logic resetIn;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  counter_sequencer_if #(.REP_W(REP_W)) sif ();

  counter_sequencer #(
    .CLK_DIV(CLK_DIV),
    .REP_W  (REP_W)
  ) dut (
    .clk    (clk),
    .resetIn(resetIn),
    .seq    (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    total++;
    if (obs != exp_v) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp_v);
    end else begin
      $display("ok   %s cyc=%0d val=%0d", tag, cyc, obs);
    end
  endtask

  function automatic int get_sig(input int sel);
    case (sel)
      S_MODE:  return int'(sif.cntMode);
      S_ENB:   return int'(sif.cntEnb);
      S_CRST:  return int'(sif.cntReset);
      S_GU:    return int'(sif.grantUser);
      S_GA:    return int'(sif.grantAuto);
      S_BUSY:  return int'(sif.busy);
      S_DONE:  return int'(sif.done);
      default: return int'(sif.passCount);
    endcase
  endfunction

  task automatic expect_at(input int c, input int sel, input int val, input string tag);
    exp_t e;
    e.cyc = c;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic expect_zero(input int c, input string tag);
    for (int s = 0; s < 8; s++) expect_at(c, s, 0, $sformatf("%s_sig%0d", tag, s));
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Scoreboard pop: compare every expectation due this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check_val(sb[i].tag, get_sig(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int g;
    int p;
    int g2;

    resetIn       = 1'b1;
    sif.reqUser   = 1'b0;
    sif.modeUser  = 3'd0;
    sif.reqAuto   = 1'b0;
    sif.modeAuto  = 3'd0;
    sif.repeats   = '0;
    sif.pause     = 1'b0;
    sif.stop      = 1'b0;
    sif.cntWrap   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    c = cyc;
    expect_zero(c + 1, "reset");
    @(negedge clk);
    resetIn = 1'b0;
    @(negedge clk);

    // 1: user playback, 2 passes
    c = cyc;
    g = c + 1;
    sif.reqUser  = 1'b1;
    sif.modeUser = 3'd1;
    sif.repeats  = 4'd2;
    expect_at(g,      S_GU,   1, "s1_grant_user");
    expect_at(g,      S_CRST, 1, "s1_cnt_reset");
    expect_at(g,      S_MODE, 1, "s1_mode");
    expect_at(g,      S_BUSY, 1, "s1_busy");
    expect_at(g + 1,  S_GU,   0, "s1_grant_drop");
    expect_at(g + 1,  S_CRST, 0, "s1_crst_drop");
    expect_at(g + 3,  S_ENB,  0, "s1_enb_pre");
    expect_at(g + 4,  S_ENB,  1, "s1_enb_first");
    expect_at(g + 5,  S_ENB,  0, "s1_enb_after");
    expect_at(g + 8,  S_ENB,  1, "s1_enb_second");
    expect_at(g + 9,  S_PASS, 1, "s1_pass1");
    expect_at(g + 10, S_DONE, 0, "s1_no_early_done");
    expect_at(g + 11, S_DONE, 1, "s1_done");
    expect_at(g + 11, S_PASS, 2, "s1_pass2");
    expect_at(g + 11, S_ENB,  0, "s1_finish_enb");
    expect_at(g + 12, S_DONE, 0, "s1_done_drop");
    expect_at(g + 12, S_BUSY, 0, "s1_idle_busy");
    expect_at(g + 12, S_PASS, 2, "s1_pass_hold");
    wait_cyc(g);      sif.reqUser = 1'b0;
    wait_cyc(g + 8);  sif.cntWrap = 1'b1;
    wait_cyc(g + 9);  sif.cntWrap = 1'b0;
    wait_cyc(g + 10); sif.cntWrap = 1'b1;
    wait_cyc(g + 11); sif.cntWrap = 1'b0;
    wait_cyc(g + 13);

    // 2: simultaneous user+auto; auto ignored while busy; stop
    c = cyc;
    g = c + 1;
    sif.reqUser  = 1'b1;
    sif.modeUser = 3'd2;
    sif.reqAuto  = 1'b1;
    sif.modeAuto = 3'd6;
    sif.repeats  = 4'd1;
    expect_at(g, S_GU,   1, "s2_grant_user");
    expect_at(g, S_GA,   0, "s2_no_grant_auto");
    expect_at(g, S_MODE, 2, "s2_mode_user");
    for (int k = 2; k <= 6; k++) expect_at(g + k, S_GA, 0, $sformatf("s2_busy_no_ga_%0d", k));
    expect_at(g + 7, S_CRST, 1, "s2_stop_crst");
    expect_at(g + 7, S_BUSY, 0, "s2_stop_busy");
    expect_at(g + 7, S_PASS, 0, "s2_stop_pass");
    expect_at(g + 7, S_GA,   0, "s2_stop_no_ga");
    expect_at(g + 8, S_CRST, 0, "s2_crst_drop");
    expect_at(g + 8, S_MODE, 2, "s2_mode_hold");
    wait_cyc(g);     sif.reqUser = 1'b0;
    wait_cyc(g + 6); sif.stop = 1'b1; sif.reqAuto = 1'b0;
    wait_cyc(g + 7); sif.stop = 1'b0;
    wait_cyc(g + 9);

    // 3: auto forever, then user preemption
    c = cyc;
    g = c + 1;
    p = g + 7;
    sif.reqAuto  = 1'b1;
    sif.modeAuto = 3'd3;
    sif.repeats  = 4'd0;
    expect_at(g,     S_GA,   1, "s3_grant_auto");
    expect_at(g,     S_GU,   0, "s3_no_gu");
    expect_at(g,     S_MODE, 3, "s3_mode_auto");
    expect_at(g,     S_CRST, 1, "s3_crst");
    expect_at(g + 4, S_PASS, 1, "s3_pass1");
    expect_at(g + 5, S_BUSY, 1, "s3_forever_busy");
    expect_at(p,     S_GU,   1, "s3_preempt_gu");
    expect_at(p,     S_CRST, 1, "s3_preempt_crst");
    expect_at(p,     S_MODE, 5, "s3_preempt_mode");
    expect_at(p,     S_PASS, 0, "s3_preempt_pass");
    expect_at(p,     S_GA,   0, "s3_preempt_no_ga");

    // 4: pause with divider at 2, wrap ignored while paused, pause+wrap
    expect_at(p + 3, S_ENB, 0, "s4_enb_div2");
    for (int k = 4; k <= 13; k++) expect_at(p + k, S_ENB, 0, $sformatf("s4_paused_enb_%0d", k));
    expect_at(p + 7,  S_PASS, 0, "s4_wrap_ignored");
    expect_at(p + 14, S_ENB,  0, "s4_resume_div2");
    expect_at(p + 15, S_ENB,  1, "s4_resume_enb");
    expect_at(p + 17, S_PASS, 1, "s4_pause_wrap_pass");
    expect_at(p + 17, S_ENB,  0, "s4_pause_wrap_enb");
    expect_at(p + 18, S_BUSY, 1, "s4_busy");
    expect_at(p + 20, S_ENB,  0, "s4_enb_pre");
    expect_at(p + 21, S_ENB,  1, "s4_enb_again");

    // 5: stop with final wrap and a user request in the same cycle
    expect_at(p + 23, S_PASS, 2, "s5_pass2");
    expect_at(p + 25, S_DONE, 0, "s5_no_done");
    expect_at(p + 25, S_CRST, 1, "s5_stop_crst");
    expect_at(p + 25, S_PASS, 0, "s5_stop_pass");
    expect_at(p + 25, S_BUSY, 0, "s5_stop_busy");
    expect_at(p + 25, S_GU,   0, "s5_stop_no_gu");
    expect_at(p + 26, S_DONE, 0, "s5_still_no_done");
    expect_at(p + 26, S_GU,   1, "s5_later_gu");
    expect_at(p + 26, S_MODE, 4, "s5_later_mode");

    wait_cyc(g);      sif.reqAuto = 1'b0;
    wait_cyc(g + 3);  sif.cntWrap = 1'b1;
    wait_cyc(g + 4);  sif.cntWrap = 1'b0;
    wait_cyc(g + 6);  sif.reqUser = 1'b1; sif.modeUser = 3'd5; sif.repeats = 4'd3;
    wait_cyc(p);      sif.reqUser = 1'b0;
    wait_cyc(p + 3);  sif.pause = 1'b1;
    wait_cyc(p + 6);  sif.cntWrap = 1'b1;
    wait_cyc(p + 7);  sif.cntWrap = 1'b0;
    wait_cyc(p + 13); sif.pause = 1'b0;
    wait_cyc(p + 16); sif.pause = 1'b1; sif.cntWrap = 1'b1;
    wait_cyc(p + 17); sif.pause = 1'b0; sif.cntWrap = 1'b0;
    wait_cyc(p + 22); sif.cntWrap = 1'b1;
    wait_cyc(p + 23); sif.cntWrap = 1'b0;
    wait_cyc(p + 24);
    sif.cntWrap  = 1'b1;
    sif.stop     = 1'b1;
    sif.reqUser  = 1'b1;
    sif.modeUser = 3'd4;
    sif.repeats  = 4'd0;
    wait_cyc(p + 25); sif.cntWrap = 1'b0; sif.stop = 1'b0;
    wait_cyc(p + 26); sif.reqUser = 1'b0;

    // 6: reset mid-run, then a mode-0 request
    g2 = p + 26;
    expect_zero(g2 + 6, "s6_reset");
    for (int k = 7; k <= 9; k++) begin
      expect_at(g2 + k, S_GU,   0, $sformatf("s6_mode0_no_gu_%0d", k));
      expect_at(g2 + k, S_BUSY, 0, $sformatf("s6_mode0_busy_%0d", k));
      expect_at(g2 + k, S_CRST, 0, $sformatf("s6_mode0_crst_%0d", k));
    end
    wait_cyc(g2 + 5);  resetIn = 1'b1; sif.reqUser = 1'b1; sif.modeUser = 3'd0;
    wait_cyc(g2 + 6);  resetIn = 1'b0;
    wait_cyc(g2 + 10); sif.reqUser = 1'b0;
    wait_cyc(g2 + 12);

    check_val("sb_leftover", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Controller for the sample-index Counter. Arbitrates playback requests from two sources: a user source (front-panel buttons) and an auto source (demo/scheduler). Drives the Counter's mode, enable and reset inputs. Generates the enable tick rate, counts completed passes using the Counter's end-of-array wrap (resetOut), and supports pause, stop and user preemption.

Parameters:
CLK_DIV, 4, cntEnb pulses once every CLK_DIV clocks while running (min 2)
REP_W, 4, width of repeat count and pass counter

Ports:
clk  input  1  system clock, all logic on rising edge
resetIn  input  1  synchronous, active-high reset
reqUser  input  1  user playback request (level, sampled each cycle)
modeUser  input  3  mode accompanying reqUser
reqAuto  input  1  auto playback request (level)
modeAuto  input  3  mode accompanying reqAuto
repeats  input  REP_W  passes to play, latched at grant; 0 = loop forever
pause  input  1  level; freezes playback while high
stop  input  1  abort playback
cntWrap  input  1  Counter resetOut (end-of-array pulse)
cntMode  output  3  mode to Counter
cntEnb  output  1  advance enable to Counter
cntReset  output  1  reset to Counter
grantUser  output  1  one-cycle acknowledge of user request
grantAuto  output  1  one-cycle acknowledge of auto request
busy  output  1  high in LOAD/RUN/PAUSED/FINISH
done  output  1  one-cycle pulse when the requested passes complete
passCount  output  REP_W  completed passes of current playback

Behaviour:
- All outputs are registered. On resetIn=1 at an edge, all outputs, the divider and passCount go to 0 and the state goes to IDLE. Reset overrides everything, including mid-playback.
- States: IDLE, LOAD, RUN, PAUSED, FINISH.
- IDLE:
  - reqUser with modeUser!=0 has priority: grantUser=1 next cycle, and cntMode, repeats and source=user are latched.
  - Otherwise reqAuto with modeAuto!=0 is granted the same way (grantAuto).
  - Either grant goes to LOAD.
  - Requests with mode 0 are never granted.
- LOAD: exactly 1 cycle. cntReset=1, divider=0, passCount=0. Next state is RUN.
- Grant latency: request sampled at edge n; grant, cntReset and new cntMode are all visible in cycle n+1.
- RUN:
  - Divider counts 0..CLK_DIV-1 and wraps.
  - cntEnb=1 for the single cycle where divider==CLK_DIV-1; otherwise 0.
  - First cntEnb occurs in cycle n+1+CLK_DIV.
- cntWrap=1 in RUN:
  - passCount increments, saturating at all-ones.
  - If repeats!=0 and passCount+1==repeats, go to FINISH.
  - If repeats==0, keep running with passCount saturating.
- FINISH: 1 cycle, done=1, cntEnb=0. Next state is IDLE; busy=0 from the following cycle.
- PAUSED:
  - pause=1 in RUN moves to PAUSED; cntEnb=0 and the divider holds its value.
  - pause=0 returns to RUN, resuming from the held divider value.
  - cntWrap is ignored while PAUSED.
- Preemption: in RUN or PAUSED with source=auto, reqUser with modeUser!=0 issues grantUser, re-latches mode/repeats, and goes to LOAD. reqAuto is ignored while busy.
- stop=1 in any non-IDLE state:
  - Go to IDLE and drive cntReset=1 for 1 cycle.
  - done=0, passCount cleared, no grant issued that cycle.
- Simultaneous events:
  - stop and reqUser: stop wins; the request may be granted from IDLE on a later cycle.
  - stop and cntWrap: stop wins, no done.
  - pause and cntWrap in RUN: the wrap is counted, then PAUSED.
  - reqUser and reqAuto in IDLE: only grantUser.
- cntMode holds its last value in IDLE; it is only changed on a grant.

Test Plan:
- Reset, then reqUser=1, modeUser=1, repeats=2, CLK_DIV=4 -> grantUser and cntReset high in cycle 1; cntEnb pulses every 4 clocks; after 2 cntWrap pulses, done=1 for one cycle, busy=0 next cycle, passCount=2.
- reqUser and reqAuto asserted in the same cycle from IDLE -> only grantUser, cntMode=modeUser; later reqAuto during RUN -> no grantAuto.
- Auto playback running (modeAuto=3, repeats=0), then reqUser modeUser=5 -> grantUser, cntReset pulse, cntMode=5, passCount=0.
- pause high for 10 cycles mid-RUN with divider=2 -> no cntEnb for 10 cycles; first cntEnb 2 cycles after pause drops (divider continues 2->3).
- stop asserted in the same cycle as the final cntWrap -> done never pulses, cntReset=1 for one cycle, state IDLE, passCount=0.
- resetIn asserted mid-RUN, and reqUser with modeUser=0 -> all outputs 0 next cycle; the mode-0 request yields no grant, busy stays 0.
